// File: rtl/branch_redirect_unit.sv
// Purpose: checks each resolved control-flow instruction against the next PC
//          fetch predicted, and on a mispredict raises a one-cycle flush plus
//          a held redirect to fetch; the oldest overlapping mispredict wins.
// Latency: mispredict presented in cycle N -> flush/redirect_valid in cycle N+1.
// Backpressure: redirect_valid/redirect_pc hold until redirect_ready; an older
//          mispredict may replace the pending redirect at any time.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   res_*                  resolved branch/jal/jalr from execute
//   rob_head_id            tag of the oldest in-flight instruction (age base)
//   redirect_valid/_pc     corrected fetch PC request, handshaked by redirect_ready
//   flush, flush_rob_id    one-cycle squash pulse and tag of the mispredicted insn
//   br_count               saturating count of resolved conditional branches
//   mispred_count          saturating count of captured mispredicts
module branch_redirect_unit #(
  parameter int ADDR_WIDTH   = 32,
  parameter int ROB_ID_WIDTH = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    res_valid,
  input  logic [ROB_ID_WIDTH-1:0] res_rob_id,
  input  logic [ADDR_WIDTH-1:0]   res_pc,
  input  logic                    res_is_cond,
  input  logic [ADDR_WIDTH-1:0]   res_pred_npc,
  input  logic                    res_actual_taken,
  input  logic [ADDR_WIDTH-1:0]   res_target,
  input  logic [ROB_ID_WIDTH-1:0] rob_head_id,
  output logic                    redirect_valid,
  output logic [ADDR_WIDTH-1:0]   redirect_pc,
  input  logic                    redirect_ready,
  output logic                    flush,
  output logic [ROB_ID_WIDTH-1:0] flush_rob_id,
  output logic [CNT_WIDTH-1:0]    br_count,
  output logic [CNT_WIDTH-1:0]    mispred_count
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   actual_npc;
  logic                    mispred;
  logic [ROB_ID_WIDTH-1:0] res_age;
  logic [ROB_ID_WIDTH-1:0] held_age;
  logic                    older;
  logic                    capture;

  // Fall-through add wraps naturally at the top of the address space.
  assign actual_npc = res_actual_taken ? res_target : res_pc + ADDR_WIDTH'(4);
  assign mispred    = res_valid && (actual_npc != res_pred_npc);

  // Ages are distances from the ROB head, so tag wrap-around orders correctly.
  // flush_rob_id doubles as the tag of the currently held redirect.
  assign res_age  = res_rob_id - rob_head_id;
  assign held_age = flush_rob_id - rob_head_id;
  assign older    = res_age < held_age;

  assign redirect_valid = (state == PEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (mispred) begin
          capture   = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        // An older mispredict takes over even when fetch accepts the current
        // redirect this cycle: that handshake completes and the new one follows
        // with no idle gap.
        if (mispred && older) begin
          capture = 1'b1;
        end else if (redirect_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush         <= 1'b0;
      flush_rob_id  <= '0;
      redirect_pc   <= '0;
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      flush <= capture;
      if (capture) begin
        redirect_pc  <= actual_npc;
        flush_rob_id <= res_rob_id;
      end
      if (res_valid && res_is_cond && (br_count != '1)) begin
        br_count <= br_count + CNT_WIDTH'(1);
      end
      if (capture && (mispred_count != '1)) begin
        mispred_count <= mispred_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_redirect_unit.sv
module tb_branch_redirect_unit;

  localparam int AW = 32;
  localparam int RW = 4;
  localparam int CW = 4;  // narrow counters so saturation is reachable quickly

  logic          clk;
  logic          rst;
  logic          res_valid;
  logic [RW-1:0] res_rob_id;
  logic [AW-1:0] res_pc;
  logic          res_is_cond;
  logic [AW-1:0] res_pred_npc;
  logic          res_actual_taken;
  logic [AW-1:0] res_target;
  logic [RW-1:0] rob_head_id;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          redirect_ready;
  logic          flush;
  logic [RW-1:0] flush_rob_id;
  logic [CW-1:0] br_count;
  logic [CW-1:0] mispred_count;

  int n_cmp;
  int n_err;

  branch_redirect_unit #(
    .ADDR_WIDTH  (AW),
    .ROB_ID_WIDTH(RW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .res_valid       (res_valid),
    .res_rob_id      (res_rob_id),
    .res_pc          (res_pc),
    .res_is_cond     (res_is_cond),
    .res_pred_npc    (res_pred_npc),
    .res_actual_taken(res_actual_taken),
    .res_target      (res_target),
    .rob_head_id     (rob_head_id),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .redirect_ready  (redirect_ready),
    .flush           (flush),
    .flush_rob_id    (flush_rob_id),
    .br_count        (br_count),
    .mispred_count   (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [RW-1:0] id, input logic [AW-1:0] pc, input logic cond,
                         input logic taken, input logic [AW-1:0] tgt, input logic [AW-1:0] pred);
    res_valid        = 1'b1;
    res_rob_id       = id;
    res_pc           = pc;
    res_is_cond      = cond;
    res_actual_taken = taken;
    res_target       = tgt;
    res_pred_npc     = pred;
  endtask

  task automatic idle_in();
    res_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    res_valid = 1'b0;
    res_rob_id = '0;
    res_pc = '0;
    res_is_cond = 1'b0;
    res_pred_npc = '0;
    res_actual_taken = 1'b0;
    res_target = '0;
    rob_head_id = '0;
    redirect_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_rv", redirect_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_frid", flush_rob_id, 0);
    chk("rst_br", br_count, 0);
    chk("rst_mp", mispred_count, 0);
    step();
    step();
    rst = 1'b0;

    // 1: correct prediction of a not-taken conditional branch
    present(4'd0, 32'h100, 1'b1, 1'b0, 32'h0, 32'h104);
    step();
    idle_in();
    chk("s1_flush", flush, 0);
    chk("s1_rv", redirect_valid, 0);
    chk("s1_br", br_count, 1);
    chk("s1_mp", mispred_count, 0);

    // 2: mispredict with fetch stalled for three cycles
    present(4'd3, 32'h200, 1'b1, 1'b1, 32'h180, 32'h204);
    step();
    idle_in();
    chk("s2_flush", flush, 1);
    chk("s2_frid", flush_rob_id, 3);
    chk("s2_rv", redirect_valid, 1);
    chk("s2_rpc", redirect_pc, 32'h180);
    chk("s2_br", br_count, 2);
    chk("s2_mp", mispred_count, 1);
    step();
    chk("s2_flush_once", flush, 0);
    chk("s2_rv_hold1", redirect_valid, 1);
    step();
    step();
    chk("s2_rv_hold3", redirect_valid, 1);
    chk("s2_rpc_hold", redirect_pc, 32'h180);
    chk("s2_frid_hold", flush_rob_id, 3);
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    chk("s2_rv_drop", redirect_valid, 0);
    step();
    chk("s2_rv_idle", redirect_valid, 0);

    // 3: head=14, held id 1 (age 3) replaced by id 15 (age 1); id 2 (age 4) ignored
    rob_head_id = 4'd14;
    present(4'd1, 32'h300, 1'b0, 1'b1, 32'h500, 32'h304);
    step();
    chk("s3a_rpc", redirect_pc, 32'h500);
    chk("s3a_frid", flush_rob_id, 1);
    chk("s3a_mp", mispred_count, 2);
    present(4'd15, 32'h310, 1'b0, 1'b1, 32'h400, 32'h0);
    step();
    chk("s3b_flush", flush, 1);
    chk("s3b_rpc", redirect_pc, 32'h400);
    chk("s3b_frid", flush_rob_id, 15);
    chk("s3b_mp", mispred_count, 3);
    present(4'd2, 32'h320, 1'b0, 1'b1, 32'h600, 32'h0);
    step();
    chk("s3c_flush", flush, 0);
    chk("s3c_rpc", redirect_pc, 32'h400);
    chk("s3c_frid", flush_rob_id, 15);
    chk("s3c_mp", mispred_count, 3);
    // same age as the held one: also ignored
    present(4'd15, 32'h310, 1'b0, 1'b1, 32'h640, 32'h0);
    step();
    chk("s3d_rpc", redirect_pc, 32'h400);
    chk("s3d_mp", mispred_count, 3);

    // 4: ready together with an older mispredict: stay pending, switch target
    present(4'd14, 32'h330, 1'b0, 1'b1, 32'h700, 32'h0);
    redirect_ready = 1'b1;
    step();
    idle_in();
    chk("s4_rv", redirect_valid, 1);
    chk("s4_rpc", redirect_pc, 32'h700);
    chk("s4_flush", flush, 1);
    chk("s4_frid", flush_rob_id, 14);
    chk("s4_mp", mispred_count, 4);
    step();
    redirect_ready = 1'b0;
    chk("s4_rv_drop", redirect_valid, 0);

    // 5: fall-through add wraps to 0 -> correctly predicted
    rob_head_id = 4'd0;
    present(4'd6, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h1234, 32'h0);
    step();
    idle_in();
    chk("s5_flush", flush, 0);
    chk("s5_rv", redirect_valid, 0);
    chk("s5_mp", mispred_count, 4);
    chk("s5_br", br_count, 2);

    // 6: asynchronous reset while a redirect is pending
    present(4'd5, 32'h800, 1'b1, 1'b1, 32'h900, 32'h804);
    step();
    idle_in();
    chk("s6_pre_rv", redirect_valid, 1);
    chk("s6_pre_br", br_count, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_rst_rv", redirect_valid, 0);
    chk("s6_rst_flush", flush, 0);
    chk("s6_rst_br", br_count, 0);
    chk("s6_rst_mp", mispred_count, 0);
    chk("s6_rst_rpc", redirect_pc, 0);
    #1;
    rst = 1'b0;
    present(4'd3, 32'h200, 1'b1, 1'b1, 32'h180, 32'h204);
    step();
    idle_in();
    chk("s6_flush", flush, 1);
    chk("s6_frid", flush_rob_id, 3);
    chk("s6_rpc", redirect_pc, 32'h180);
    chk("s6_mp", mispred_count, 1);
    step();
    chk("s6_flush_once", flush, 0);
    chk("s6_rv_hold", redirect_valid, 1);
    redirect_ready = 1'b1;
    step();
    chk("s6_rv_drop", redirect_valid, 0);

    // Saturation: counters stop at all-ones
    for (int i = 0; i < 20; i++) begin
      present(4'd1, 32'h1000, 1'b1, 1'b1, 32'h2000, 32'h1004);
      step();
      idle_in();
      step();
    end
    chk("sat_br", br_count, 15);
    chk("sat_mp", mispred_count, 15);
    redirect_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
